// File: rtl/dfu_boot_sequencer.sv
// Boot/reset sequencer downstream of usb_dfu_core: sequences the DFU core
// reset, the USB pull-up, the user-image boot request and the status LEDs
// with one explicit state machine. All outputs come straight from flops.
module dfu_boot_sequencer #(
    parameter int unsigned USB_RST_CYCLES  = 65535,
    parameter int unsigned AUTOBOOT_CYCLES = 60000000,
    parameter int unsigned DETACH_CYCLES   = 1200000,
    parameter int unsigned LED_TICK_BIT    = 20
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] dfu_state,
    input  logic       dfu_detach,
    input  logic       autoboot_dis,
    output logic       core_reset,
    output logic       usb_pull_en,
    output logic       boot_req,
    output logic       led_n,
    output logic [3:0] led_pattern,
    output logic [2:0] seq_state
);

    // Each counter only ever counts 0..N-1, so clog2(N) bits suffice.
    localparam int unsigned RST_W  = (USB_RST_CYCLES  > 1) ? $clog2(USB_RST_CYCLES)  : 1;
    localparam int unsigned AUTO_W = (AUTOBOOT_CYCLES > 1) ? $clog2(AUTOBOOT_CYCLES) : 1;
    localparam int unsigned DET_W  = (DETACH_CYCLES   > 1) ? $clog2(DETACH_CYCLES)   : 1;

    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(USB_RST_CYCLES - 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTOBOOT_CYCLES - 1);
    localparam logic [DET_W-1:0]  DET_LAST  = DET_W'(DETACH_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_IDLE   = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_DETACH = 3'd3,
        ST_BOOT   = 3'd4
    } seq_state_t;

    seq_state_t                state_r;
    seq_state_t                state_nxt_s;
    logic [RST_W-1:0]          rst_cnt_r;
    logic [RST_W-1:0]          rst_cnt_nxt_s;
    logic [AUTO_W-1:0]         auto_cnt_r;
    logic [AUTO_W-1:0]         auto_cnt_nxt_s;
    logic [DET_W-1:0]          det_cnt_r;
    logic [DET_W-1:0]          det_cnt_nxt_s;
    logic [LED_TICK_BIT-1:0]   led_cnt_r;
    logic                      tick_s;
    logic                      blink_r;
    logic                      blink_nxt_s;
    logic [2:0]                phase_r;
    logic [2:0]                phase_nxt_s;
    logic                      cylon_now_s;
    logic                      core_reset_nxt_s;
    logic                      usb_pull_en_nxt_s;
    logic                      boot_req_nxt_s;
    logic                      led_n_nxt_s;
    logic [3:0]                led_pattern_nxt_s;

    // Bouncing single-LED pattern for each of the six cylon phases.
    function automatic logic [3:0] cylon_pattern(input logic [2:0] phase);
        logic [3:0] pat;
        case (phase)
            3'd0:    pat = 4'b0001;
            3'd1:    pat = 4'b0010;
            3'd2:    pat = 4'b0100;
            3'd3:    pat = 4'b1000;
            3'd4:    pat = 4'b0100;
            3'd5:    pat = 4'b0010;
            default: pat = 4'b0001;
        endcase
        return pat;
    endfunction

    assign tick_s      = &led_cnt_r;
    assign cylon_now_s = (state_r == ST_ACTIVE) || (state_r == ST_DETACH);
    assign seq_state   = state_r;

    // Next state and per-state counters; a counter clears whenever its state is left.
    always_comb begin
        state_nxt_s    = state_r;
        rst_cnt_nxt_s  = '0;
        auto_cnt_nxt_s = '0;
        det_cnt_nxt_s  = '0;
        case (state_r)
            ST_RST: begin
                if (rst_cnt_r == RST_LAST) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    rst_cnt_nxt_s = rst_cnt_r + RST_W'(1);
                end
            end
            ST_IDLE: begin
                if (dfu_detach) begin
                    state_nxt_s = ST_DETACH;
                end else if (dfu_state > 8'h02) begin
                    state_nxt_s = ST_ACTIVE;
                end else if (auto_cnt_r == AUTO_LAST) begin
                    if (autoboot_dis) begin
                        auto_cnt_nxt_s = auto_cnt_r;
                    end else begin
                        state_nxt_s = ST_DETACH;
                    end
                end else begin
                    auto_cnt_nxt_s = auto_cnt_r + AUTO_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (dfu_detach) begin
                    state_nxt_s = ST_DETACH;
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            ST_DETACH: begin
                if (det_cnt_r == DET_LAST) begin
                    state_nxt_s = ST_BOOT;
                end else begin
                    det_cnt_nxt_s = det_cnt_r + DET_W'(1);
                end
            end
            ST_BOOT: begin
                state_nxt_s = ST_BOOT;
            end
            default: begin
                state_nxt_s = ST_RST;
            end
        endcase
    end

    // LED animation state: blink toggles on every tick, cylon phase restarts on entering the cylon states.
    always_comb begin
        blink_nxt_s = tick_s ? ~blink_r : blink_r;
        if (((state_nxt_s == ST_ACTIVE) || (state_nxt_s == ST_DETACH)) && !cylon_now_s) begin
            phase_nxt_s = 3'd0;
        end else if (cylon_now_s && tick_s) begin
            phase_nxt_s = (phase_r == 3'd5) ? 3'd0 : phase_r + 3'd1;
        end else if (cylon_now_s) begin
            phase_nxt_s = phase_r;
        end else begin
            phase_nxt_s = 3'd0;
        end
    end

    // Output values for the state being entered, so outputs flip on the same edge as the state.
    always_comb begin
        core_reset_nxt_s  = 1'b1;
        usb_pull_en_nxt_s = 1'b0;
        boot_req_nxt_s    = 1'b0;
        led_n_nxt_s       = 1'b1;
        led_pattern_nxt_s = 4'b0000;
        case (state_nxt_s)
            ST_IDLE: begin
                core_reset_nxt_s  = 1'b0;
                usb_pull_en_nxt_s = 1'b1;
                led_pattern_nxt_s = {3'b000, blink_nxt_s};
                led_n_nxt_s       = ~blink_nxt_s;
            end
            ST_ACTIVE: begin
                core_reset_nxt_s  = 1'b0;
                usb_pull_en_nxt_s = 1'b1;
                led_pattern_nxt_s = cylon_pattern(phase_nxt_s);
                led_n_nxt_s       = ~(|cylon_pattern(phase_nxt_s));
            end
            ST_DETACH: begin
                core_reset_nxt_s  = 1'b0;
                usb_pull_en_nxt_s = 1'b0;
                led_pattern_nxt_s = cylon_pattern(phase_nxt_s);
                led_n_nxt_s       = ~(|cylon_pattern(phase_nxt_s));
            end
            ST_BOOT: begin
                core_reset_nxt_s  = 1'b1;
                boot_req_nxt_s    = 1'b1;
                led_pattern_nxt_s = 4'b1111;
                led_n_nxt_s       = 1'b0;
            end
            default: begin
                core_reset_nxt_s  = 1'b1;
                usb_pull_en_nxt_s = 1'b0;
            end
        endcase
    end

    // State, counters, LED animation and all outputs; everything clears asynchronously on resetn.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_RST;
            rst_cnt_r   <= '0;
            auto_cnt_r  <= '0;
            det_cnt_r   <= '0;
            led_cnt_r   <= '0;
            blink_r     <= 1'b0;
            phase_r     <= 3'd0;
            core_reset  <= 1'b1;
            usb_pull_en <= 1'b0;
            boot_req    <= 1'b0;
            led_n       <= 1'b1;
            led_pattern <= 4'b0000;
        end else begin
            state_r     <= state_nxt_s;
            rst_cnt_r   <= rst_cnt_nxt_s;
            auto_cnt_r  <= auto_cnt_nxt_s;
            det_cnt_r   <= det_cnt_nxt_s;
            led_cnt_r   <= led_cnt_r + LED_TICK_BIT'(1);
            blink_r     <= blink_nxt_s;
            phase_r     <= phase_nxt_s;
            core_reset  <= core_reset_nxt_s;
            usb_pull_en <= usb_pull_en_nxt_s;
            boot_req    <= boot_req_nxt_s;
            led_n       <= led_n_nxt_s;
            led_pattern <= led_pattern_nxt_s;
        end
    end

endmodule

// File: tb/tb_dfu_boot_sequencer.sv
// Scoreboard bench for dfu_boot_sequencer: a driver applies directed and
// random stimulus at the falling edge and pushes the reference model's
// expected outputs; a monitor pops and compares just after each rising edge.
module tb_dfu_boot_sequencer;

    localparam int URST = 4;
    localparam int AUTO = 20;
    localparam int DET  = 3;
    localparam int LTB  = 2;

    logic       clk;
    logic       resetn;
    logic [7:0] dfu_state;
    logic       dfu_detach;
    logic       autoboot_dis;
    logic       core_reset;
    logic       usb_pull_en;
    logic       boot_req;
    logic       led_n;
    logic [3:0] led_pattern;
    logic [2:0] seq_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [10:0] exp_q[$];

    // Reference model: life-cycle mode plus elapsed times and tick counts.
    int m_mode;     // 0 rst, 1 idle, 2 active, 3 detach, 4 boot
    int m_elapsed;  // cycles spent in the current mode
    int m_cyc;      // cycles since reset release
    int m_ticks;    // LED ticks since reset release
    int m_cyl;      // ticks since entering the cylon animation
    int pat_tbl[6] = '{1, 2, 4, 8, 4, 2};

    localparam logic [10:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 3'd0};

    dfu_boot_sequencer #(
        .USB_RST_CYCLES (URST),
        .AUTOBOOT_CYCLES(AUTO),
        .DETACH_CYCLES  (DET),
        .LED_TICK_BIT   (LTB)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .dfu_state   (dfu_state),
        .dfu_detach  (dfu_detach),
        .autoboot_dis(autoboot_dis),
        .core_reset  (core_reset),
        .usb_pull_en (usb_pull_en),
        .boot_req    (boot_req),
        .led_n       (led_n),
        .led_pattern (led_pattern),
        .seq_state   (seq_state)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    function automatic logic [10:0] dut_vec();
        return {core_reset, usb_pull_en, boot_req, led_n, led_pattern, seq_state};
    endfunction

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s @%0t: got {crst,pull,boot,led_n,pat,st}=%b expected %b",
                     name, $time, got, want);
        end
    endtask

    function automatic logic [10:0] model_expect();
        logic [3:0] pat;
        logic [2:0] st;
        st = 3'(m_mode);
        case (m_mode)
            1: begin
                pat = {3'b000, 1'(m_ticks % 2)};
                return {1'b0, 1'b1, 1'b0, ~pat[0], pat, st};
            end
            2: begin
                pat = 4'(pat_tbl[m_cyl % 6]);
                return {1'b0, 1'b1, 1'b0, 1'b0, pat, st};
            end
            3: begin
                pat = 4'(pat_tbl[m_cyl % 6]);
                return {1'b0, 1'b0, 1'b0, 1'b0, pat, st};
            end
            4: return {1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, st};
            default: return RESET_VEC;
        endcase
    endfunction

    // Advance the model by one rising edge given the inputs presented before it.
    task automatic model_edge(input logic rn, input logic [7:0] st, input logic det, input logic dis);
        int nm;
        bit tick;
        bit was_cyl;
        if (!rn) begin
            m_mode = 0; m_elapsed = 0; m_cyc = 0; m_ticks = 0; m_cyl = 0;
            return;
        end
        tick = ((m_cyc % (1 << LTB)) == ((1 << LTB) - 1));
        m_cyc++;
        if (tick) m_ticks++;
        nm = m_mode;
        case (m_mode)
            0: if (m_elapsed == URST - 1) nm = 1;
            1: begin
                if (det) nm = 3;
                else if (st > 8'h02) nm = 2;
                else if (!dis && m_elapsed >= AUTO - 1) nm = 3;
            end
            2: if (det) nm = 3;
            3: if (m_elapsed == DET - 1) nm = 4;
            default: nm = m_mode;
        endcase
        was_cyl = (m_mode == 2) || (m_mode == 3);
        if (nm != m_mode) m_elapsed = 0;
        else m_elapsed++;
        if (!was_cyl && (nm == 2 || nm == 3)) m_cyl = 0;
        else if (was_cyl && tick) m_cyl++;
        m_mode = nm;
    endtask

    // Apply one cycle of stimulus and queue the expected post-edge outputs.
    task automatic drive(input logic rn, input logic [7:0] st, input logic det, input logic dis);
        @(negedge clk);
        dfu_state    = st;
        dfu_detach   = det;
        autoboot_dis = dis;
        if (resetn && !rn) begin
            resetn = 1'b0;
            #1;
            check("async_reset", dut_vec(), RESET_VEC);
        end
        resetn = rn;
        model_edge(rn, st, det, dis);
        exp_q.push_back(model_expect());
    endtask

    task automatic run(input int n, input logic [7:0] st, input logic det, input logic dis);
        for (int i = 0; i < n; i++) drive(1'b1, st, det, dis);
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h02, 1'b0, 1'b0);
        drive(1'b0, 8'h02, 1'b0, 1'b0);
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation after every edge.
    initial begin
        logic [10:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle", dut_vec(), e);
            end
        end
    end

    initial begin
        logic       rn;
        logic [7:0] st;
        logic       det;
        logic       dis;
        int         r;
        resetn       = 1'b0;
        dfu_state    = 8'h02;
        dfu_detach   = 1'b0;
        autoboot_dis = 1'b0;
        m_mode = 0; m_elapsed = 0; m_cyc = 0; m_ticks = 0; m_cyl = 0;

        // Power-up, reset sequence and auto boot.
        do_reset();
        run(40, 8'h02, 1'b0, 1'b0);

        // Host activity cancels auto boot; later detach still boots.
        do_reset();
        run(URST + 10, 8'h02, 1'b0, 1'b0);
        run(3, 8'h05, 1'b0, 1'b0);
        run(1000, 8'h02, 1'b0, 1'b0);
        run(1, 8'h02, 1'b1, 1'b0);
        run(10, 8'h02, 1'b0, 1'b0);

        // Detach and active dfu_state in the same IDLE cycle: detach wins.
        do_reset();
        run(URST + 3, 8'h02, 1'b0, 1'b0);
        run(1, 8'h03, 1'b1, 1'b0);
        run(10, 8'h03, 1'b0, 1'b0);

        // Auto boot disabled by strap, then released.
        do_reset();
        run(104, 8'h02, 1'b0, 1'b1);
        run(5, 8'h02, 1'b0, 1'b0);

        // Reset mid-DETACH (count=1) and again in BOOT.
        do_reset();
        run(URST + AUTO + 1, 8'h02, 1'b0, 1'b0);
        do_reset();
        run(URST + AUTO + DET + 10, 8'h02, 1'b0, 1'b0);
        do_reset();
        run(10, 8'h02, 1'b0, 1'b0);

        // Cylon in ACTIVE, then detach through to BOOT.
        do_reset();
        run(URST + 2, 8'h02, 1'b0, 1'b0);
        run(40, 8'h04, 1'b0, 1'b0);
        run(1, 8'h04, 1'b1, 1'b0);
        run(8, 8'h04, 1'b1, 1'b0);

        // Random episodes.
        dis = 1'b0;
        for (int ep = 0; ep < 40; ep++) begin
            do_reset();
            for (int c = 0; c < 80; c++) begin
                rn = ($urandom_range(0, 199) != 0);
                r  = $urandom_range(0, 9);
                if (r < 6)      st = 8'h02;
                else if (r < 8) st = 8'($urandom_range(3, 255));
                else            st = 8'($urandom_range(0, 1));
                det = ($urandom_range(0, 49) == 0);
                if ($urandom_range(0, 29) == 0) dis = ~dis;
                drive(rn, st, det, dis);
            end
        end

        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
